// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and counter sizing.
// Optional borrow-in chaining is enabled by SERIAL_SUB_BORROW_IN_EN.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must hold 0..WIDTH so it never wraps inside one operation.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for serial_subtractor.
// borrow_in is present only when SERIAL_SUB_BORROW_IN_EN is defined.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 3
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_BORROW_IN_EN
  logic             borrow_in;

  modport master (
    output in_valid, a, b, borrow_in, out_ready,
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, a, b, borrow_in, out_ready,
    output in_ready, out_valid, diff, borrow_out
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow_out
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow_out
  );
`endif

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic a_xor_b;

  assign a_xor_b = a ^ b;
  assign d       = a_xor_b ^ bin;
  assign bout    = (~a & b) | (~a_xor_b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b (mod 2^WIDTH) over WIDTH cycles.
// Define SERIAL_SUB_BORROW_IN_EN to seed the borrow from bus.borrow_in for chaining.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state;
  state_e           state_next;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_shift_c;
  logic [CNT_W-1:0] cnt;
  logic             br;

  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic             accept_c;
  logic             shift_c;
  logic             last_c;
  logic             seed_c;
  logic             d_c;
  logic             bout_c;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign seed_c = bus.borrow_in;
`else
  assign seed_c = 1'b0;
`endif

  full_subtractor u_full_subtractor (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d_c),
    .bout (bout_c)
  );

  // New difference bit enters from the MSB side so the word is aligned after WIDTH shifts.
  assign diff_shift_c = WIDTH'({d_c, diff_sr} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    shift_c    = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          accept_c   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        shift_c = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Serial datapath: operand shift registers, partial difference, borrow and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= 1'b0;
    end else if (accept_c) begin
      a_sr    <= bus.a;
      b_sr    <= bus.b;
      diff_sr <= '0;
      cnt     <= '0;
      br      <= seed_c;
    end else if (shift_c) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_shift_c;
      cnt     <= cnt + CNT_W'(1);
      br      <= bout_c;
    end
  end

  // Result registers load only on the final bit, so they hold through DONE and the following IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (last_c) begin
      diff_q   <= diff_shift_c;
      borrow_q <= bout_c;
    end
  end

  // Handshake flags track the upcoming state so they are registered yet cycle-aligned with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      in_ready_q  <= (state_next == IDLE);
      out_valid_q <= (state_next == DONE);
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH=3.
// Borrow-in vectors run only when SERIAL_SUB_BORROW_IN_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned WIDTH = 3;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] av, input logic [2:0] bv, input logic bin);
    bus.a = av;
    bus.b = bv;
`ifdef SERIAL_SUB_BORROW_IN_EN
    bus.borrow_in = bin;
`else
    if (bin) $display("note: borrow_in request ignored in this build");
`endif
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && bus.in_ready !== 1'b1; i++) step();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s wait_ready: in_ready=%b expected 1 within 20 cycles", name, bus.in_ready);
    end
  endtask

  // Full operation with out_ready high: latency, result and return to IDLE.
  task automatic do_op(input string name, input logic [2:0] av, input logic [2:0] bv,
                       input logic bin, input logic [2:0] ed, input logic eb);
    wait_ready(name);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(av, bv, bin);
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_in_ready: got %b expected 0", name, bus.in_ready);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      total++;
      if (bus.out_valid !== (i == 3)) begin
        bad++;
        $display("FAIL %s out_valid_cycle%0d: got %b expected %b", name, i, bus.out_valid, (i == 3));
      end
    end
    total++;
    if (bus.diff !== ed) begin
      bad++;
      $display("FAIL %s diff: got %0d expected %0d", name, bus.diff, ed);
    end
    total++;
    if (bus.borrow_out !== eb) begin
      bad++;
      $display("FAIL %s borrow_out: got %b expected %b", name, bus.borrow_out, eb);
    end
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s back_to_idle: out_valid=%b in_ready=%b expected 0/1", name, bus.out_valid, bus.in_ready);
    end
    total++;
    if (bus.diff !== ed) begin
      bad++;
      $display("FAIL %s diff_hold_idle: got %0d expected %0d", name, bus.diff, ed);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(3'd0, 3'd0, 1'b0);
    #12;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 3'd0 || bus.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b diff=%0d borrow_out=%b expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow_out);
    end
    #6 rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_op("sub_5_3", 3'd5, 3'd3, 1'b0, 3'd2, 1'b0);
    do_op("sub_3_5", 3'd3, 3'd5, 1'b0, 3'd6, 1'b1);
    do_op("sub_0_7", 3'd0, 3'd7, 1'b0, 3'd1, 1'b1);
    do_op("sub_7_7", 3'd7, 3'd7, 1'b0, 3'd0, 1'b0);
  endtask

  // in_valid held high: second accept lands one cycle after the output handshake.
  task automatic test_back_to_back();
    wait_ready("b2b");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(3'd7, 3'd7, 1'b0);
    step();
    drive(3'd2, 3'd1, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      total++;
      if (bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b in_ready_busy%0d: got %b expected 0", i, bus.in_ready);
      end
      step();
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 3'd0 || bus.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b first_result: out_valid=%b diff=%0d borrow_out=%b expected 1/0/0",
               bus.out_valid, bus.diff, bus.borrow_out);
    end
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b idle_gap: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
    step();
    bus.in_valid = 1'b0;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL b2b second_accept: in_ready=%b expected 0", bus.in_ready);
    end
    step();
    step();
    step();
    total++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 3'd1 || bus.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b second_result: out_valid=%b diff=%0d borrow_out=%b expected 1/1/0",
               bus.out_valid, bus.diff, bus.borrow_out);
    end
    step();
  endtask

  task automatic test_backpressure();
    wait_ready("bp");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    drive(3'd6, 3'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    bus.in_valid = 1'b1;
    drive(3'd0, 3'd7, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 3'd5 || bus.borrow_out !== 1'b0 || bus.in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp hold%0d: out_valid=%b diff=%0d borrow_out=%b in_ready=%b expected 1/5/0/0",
                 i, bus.out_valid, bus.diff, bus.borrow_out, bus.in_ready);
      end
      bus.in_valid = (i == 2);
      drive(3'd1, 3'd2, 1'b0);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 3'd5) begin
      bad++;
      $display("FAIL bp release: out_valid=%b in_ready=%b diff=%0d expected 0/1/5",
               bus.out_valid, bus.in_ready, bus.diff);
    end
    step();
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp no_stray_op: in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    wait_ready("rst_busy");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    drive(3'd5, 3'd1, 1'b0);
    step();
    bus.in_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== 3'd0 || bus.borrow_out !== 1'b0) begin
      bad++;
      $display("FAIL rst_busy outputs: in_ready=%b out_valid=%b diff=%0d borrow_out=%b expected 1/0/0/0",
               bus.in_ready, bus.out_valid, bus.diff, bus.borrow_out);
    end
    step();
    #2 rst_n = 1'b1;
    do_op("rst_busy_next", 3'd4, 3'd2, 1'b0, 3'd2, 1'b0);
  endtask

`ifdef SERIAL_SUB_BORROW_IN_EN
  task automatic test_borrow_in();
    do_op("bin_4_1_1", 3'd4, 3'd1, 1'b1, 3'd2, 1'b0);
    do_op("bin_0_0_1", 3'd0, 3'd0, 1'b1, 3'd7, 1'b1);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_busy();
`ifdef SERIAL_SUB_BORROW_IN_EN
    test_borrow_in();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
